// File: rtl/flow_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_vga_pkg
// Description : Shared types and constants for the VGA plot scheduler:
//               FSM state enum, default screen geometry, coordinate widths
//               and default color width.
// Revision    : 1.0 - initial release
// ============================================================================
package flow_vga_pkg;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;
    localparam int X_W              = 8;
    localparam int Y_W              = 7;
    localparam int COLOR_W_DEFAULT  = 15;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_sweep_counter
// Description : Raster (sx, sy) counter for the screen-clear sweep. start
//               zeroes both counters (priority over enable); enable advances
//               sx, wrapping at SCREEN_W-1 and stepping sy. last flags the
//               final pixel (SCREEN_W-1, SCREEN_H-1).
// Ports       : clock, resetn (async active-low), start, enable,
//               sx[X_W], sy[Y_W], last
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sweep_counter
    import flow_vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic           enable,
    output logic [X_W-1:0] sx,
    output logic [Y_W-1:0] sy,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    logic x_at_end;
    logic y_at_end;

    // Exact compares against the last coordinate; no reliance on the
    // natural counter overflow.
    assign x_at_end = (sx == X_LAST);
    assign y_at_end = (sy == Y_LAST);
    assign last     = x_at_end && y_at_end;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sx <= '0;
            sy <= '0;
        end else if (start) begin
            sx <= '0;
            sy <= '0;
        end else if (enable) begin
            if (x_at_end) begin
                sx <= '0;
                sy <= y_at_end ? '0 : sy + Y_W'(1);
            end else begin
                sx <= sx + X_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_scheduler
// Description : Arbitrates the single VGA plot port between CPU plot
//               requests (valid/ready) and a full-screen clear engine that
//               sweeps one pixel per cycle. All vga_* outputs are registered.
// Ports       : clock, resetn (async active-low)
//               cpu_valid, cpu_ready, cpu_x, cpu_y, cpu_color
//               clear_start, clear_color, busy, clear_done
//               vga_x, vga_y, vga_color, vga_plot
//               oob_flag (only with FLOW_VGA_BOUNDS_CHECK_EN)
// Options     : FLOW_VGA_BOUNDS_CHECK_EN - drop CPU plots outside the screen
//               (still handshaken) and pulse oob_flag instead of plotting.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_scheduler
    import flow_vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT,
    parameter int COLOR_W  = COLOR_W_DEFAULT
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cpu_valid,
    output logic               cpu_ready,
    input  logic [X_W-1:0]     cpu_x,
    input  logic [Y_W-1:0]     cpu_y,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               busy,
    output logic               clear_done,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
    ,
    output logic               oob_flag
`endif
);

    state_t             state;
    logic [COLOR_W-1:0] fill_color;
    // Set once the final sweep pixel has been registered; the following
    // cycle is the drain cycle that returns to IDLE and pulses clear_done.
    logic               final_issued;
    logic [X_W-1:0]     sx;
    logic [Y_W-1:0]     sy;
    logic               sweep_last;
    logic               sweep_enable;
    logic               cpu_accept;
    logic               cpu_oob;

    assign cpu_ready    = (state == IDLE) && !clear_start;
    assign cpu_accept   = cpu_valid && cpu_ready;
    assign sweep_enable = (state == CLEAR) && !final_issued;

`ifdef FLOW_VGA_BOUNDS_CHECK_EN
    assign cpu_oob = ({1'b0, cpu_x} >= (X_W + 1)'(SCREEN_W)) ||
                     ({1'b0, cpu_y} >= (Y_W + 1)'(SCREEN_H));
`else
    assign cpu_oob = 1'b0;
`endif

    vga_sweep_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_sweep (
        .clock  (clock),
        .resetn (resetn),
        .start  (clear_start),
        .enable (sweep_enable),
        .sx     (sx),
        .sy     (sy),
        .last   (sweep_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            busy         <= 1'b0;
            clear_done   <= 1'b0;
            vga_plot     <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_color    <= '0;
            fill_color   <= '0;
            final_issued <= 1'b0;
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
            oob_flag     <= 1'b0;
`endif
        end else begin
            vga_plot   <= 1'b0;
            clear_done <= 1'b0;
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
            oob_flag   <= 1'b0;
`endif
            // clear_start wins in either state: a restart mid-sweep simply
            // re-latches the color and the counter returns to (0,0).
            if (clear_start) begin
                state        <= CLEAR;
                busy         <= 1'b1;
                fill_color   <= clear_color;
                final_issued <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cpu_accept) begin
                            if (!cpu_oob) begin
                                vga_plot  <= 1'b1;
                                vga_x     <= cpu_x;
                                vga_y     <= cpu_y;
                                vga_color <= cpu_color;
                            end
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
                            else begin
                                oob_flag <= 1'b1;
                            end
`endif
                        end
                    end
                    CLEAR: begin
                        if (final_issued) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            clear_done   <= 1'b1;
                            final_issued <= 1'b0;
                        end else begin
                            vga_plot     <= 1'b1;
                            vga_x        <= sx;
                            vga_y        <= sy;
                            vga_color    <= fill_color;
                            final_issued <= sweep_last;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_scheduler
// Description : Self-checking bench for vga_plot_scheduler. A driver applies
//               directed and random stimulus, advances a pixel-index model
//               of the scheduler and queues the expected strobe for each
//               cycle; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_plot_scheduler;

    localparam int W       = 160;
    localparam int H       = 120;
    localparam int CW      = 15;
    localparam int N       = W * H;
    localparam int K_PLOT  = 0;
    localparam int K_DONE  = 1;
    localparam int K_OOB   = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int color;
        int cyc;
    } exp_t;

    logic          clk;
    logic          resetn;
    logic          cpu_valid;
    logic          cpu_ready;
    logic [7:0]    cpu_x;
    logic [6:0]    cpu_y;
    logic [CW-1:0] cpu_color;
    logic          clear_start;
    logic [CW-1:0] clear_color;
    logic          busy;
    logic          clear_done;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CW-1:0] vga_color;
    logic          vga_plot;
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
    logic          oob_flag;
`endif

    vga_plot_scheduler dut (
        .clock       (clk),
        .resetn      (resetn),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_x       (cpu_x),
        .cpu_y       (cpu_y),
        .cpu_color   (cpu_color),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy),
        .clear_done  (clear_done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_plot    (vga_plot)
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
        ,
        .oob_flag    (oob_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];

    // Reference model: a sweep is just a pixel index 0..N-1, followed by one
    // cycle announcing completion (index == N).
    bit   m_sweep = 1'b0;
    int   m_idx   = 0;
    int   m_fill  = 0;

    function automatic bit oob_model(input int x, input int y);
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
        return (x >= W) || (y >= H);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input int kind, input int x, input int y, input int c);
        exp_t e;
        e.kind  = kind;
        e.x     = x;
        e.y     = y;
        e.color = c;
        e.cyc   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic step(input bit v, input int x, input int y, input int col,
                        input bit cs, input int cc, output bit accepted);
        cpu_valid   = v;
        cpu_x       = 8'(x);
        cpu_y       = 7'(y);
        cpu_color   = CW'(col);
        clear_start = cs;
        clear_color = CW'(cc);
        #1;
        checks++;
        if (cpu_ready !== (!m_sweep && !cs)) begin
            errors++;
            $display("FAIL cpu_ready cyc %0d got %b exp %b", cyc, cpu_ready, (!m_sweep && !cs));
        end
        checks++;
        if (busy !== m_sweep) begin
            errors++;
            $display("FAIL busy cyc %0d got %b exp %b", cyc, busy, m_sweep);
        end
        accepted = v && !m_sweep && !cs;
        if (cs) begin
            m_sweep = 1'b1;
            m_idx   = 0;
            m_fill  = cc & ((1 << CW) - 1);
        end else if (m_sweep) begin
            if (m_idx < N) begin
                push(K_PLOT, m_idx % W, m_idx / W, m_fill);
                m_idx++;
            end else begin
                push(K_DONE, 0, 0, 0);
                m_sweep = 1'b0;
            end
        end else if (v) begin
            if (oob_model(x, y)) push(K_OOB, 0, 0, 0);
            else                 push(K_PLOT, x, y, col & ((1 << CW) - 1));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        bit a;
        step(1'b0, 0, 0, 0, 1'b0, 0, a);
    endtask

    task automatic do_reset();
        cpu_valid   = 1'b0;
        clear_start = 1'b0;
        resetn      = 1'b0;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0 ||
            vga_x !== 8'd0 || vga_y !== 7'd0 || vga_color !== '0) begin
            errors++;
            $display("FAIL reset_outputs got plot=%b busy=%b done=%b x=%0d y=%0d c=%h exp all 0",
                     vga_plot, busy, clear_done, vga_x, vga_y, vga_color);
        end
        q.delete();
        m_sweep = 1'b0;
        m_idx   = 0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        resetn = 1'b1;
        #1;
    endtask

    task automatic run_until_idle();
        int guard;
        guard = 0;
        while (m_sweep && guard < N + 10) begin
            idle();
            guard++;
        end
        checks++;
        if (m_sweep) begin
            errors++;
            $display("FAIL sweep_timeout got still_busy exp idle within %0d cycles", N + 10);
        end
    endtask

    task automatic run_to_index(input int target);
        int guard;
        guard = 0;
        while (m_idx != target && guard < N + 10) begin
            idle();
            guard++;
        end
        checks++;
        if (m_idx != target) begin
            errors++;
            $display("FAIL seek_index got %0d exp %0d", m_idx, target);
        end
    endtask

    // Monitor: one expected strobe per stamped cycle.
    always @(negedge clk) begin : mon
        int nstrobe;
        int gk;
        nstrobe = int'(vga_plot) + int'(clear_done);
`ifdef FLOW_VGA_BOUNDS_CHECK_EN
        nstrobe = nstrobe + int'(oob_flag);
`endif
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe got none exp kind=%0d at cyc %0d", q[0].kind, q[0].cyc);
            void'(q.pop_front());
        end
        if (nstrobe > 0) begin
            gk = vga_plot ? K_PLOT : (clear_done ? K_DONE : K_OOB);
            checks++;
            if (nstrobe > 1) begin
                errors++;
                $display("FAIL multi_strobe cyc %0d got %0d strobes exp 1", cyc, nstrobe);
            end else if (q.size() == 0 || q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_strobe cyc %0d got kind=%0d (%0d,%0d,%h) exp none",
                         cyc, gk, vga_x, vga_y, vga_color);
            end else begin
                if (gk != q[0].kind ||
                    (gk == K_PLOT && (int'(vga_x) != q[0].x || int'(vga_y) != q[0].y ||
                                      int'(vga_color) != q[0].color))) begin
                    errors++;
                    $display("FAIL strobe cyc %0d got kind=%0d (%0d,%0d,%h) exp kind=%0d (%0d,%0d,%h)",
                             cyc, gk, vga_x, vga_y, vga_color,
                             q[0].kind, q[0].x, q[0].y, q[0].color);
                end
                void'(q.pop_front());
            end
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe got none exp kind=%0d (%0d,%0d) at cyc %0d",
                     q[0].kind, q[0].x, q[0].y, cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int guard;
        resetn      = 1'b0;
        cpu_valid   = 1'b0;
        cpu_x       = '0;
        cpu_y       = '0;
        cpu_color   = '0;
        clear_start = 1'b0;
        clear_color = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single CPU plot, then an idle cycle.
        step(1'b1, 10, 20, 15'h7C00, 1'b0, 0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL single_accept got 0 exp 1");
        end
        idle();
        idle();

        // Full clear.
        step(1'b0, 0, 0, 0, 1'b1, 15'h001F, acc);
        run_until_idle();
        idle();

        // Contention: held CPU request loses to clear, lands after clear_done.
        step(1'b1, 5, 5, 15'h1234, 1'b1, 15'h7FFF, acc);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < N + 10) begin
            step(1'b1, 5, 5, 15'h1234, 1'b0, 0, acc);
            guard++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL contention_accept got 0 exp 1");
        end
        idle();
        idle();

        // Restart mid-sweep at (40,3).
        step(1'b0, 0, 0, 0, 1'b1, 15'h5555, acc);
        run_to_index(3 * W + 40);
        step(1'b0, 0, 0, 0, 1'b1, 15'h03E0, acc);
        run_until_idle();
        idle();

        // Async reset mid-sweep at (80,60).
        step(1'b0, 0, 0, 0, 1'b1, 15'h2AAA, acc);
        run_to_index(60 * W + 80);
        do_reset();
        idle();
        step(1'b1, 3, 4, 15'h0F0F, 1'b0, 0, acc);
        idle();

        // Boundary: x just past the screen edge.
        step(1'b1, 160, 0, 15'h4321, 1'b0, 0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL oob_accept got 0 exp 1");
        end
        step(1'b1, 159, 119, 15'h0001, 1'b0, 0, acc);
        step(1'b1, 0, 120, 15'h0002, 1'b0, 0, acc);
        idle();

        // Random traffic with occasional clear starts.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 32767)),
                 ($urandom_range(0, 99) == 0), int'($urandom_range(0, 32767)), acc);
        end
        if (m_sweep) do_reset();
        repeat (3) idle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
